// File: rtl/seq_multiplier_pkg.sv
// Shared types and helpers for the iterative shift-add multiplier.
// Optional early termination is enabled with SEQ_MULTIPLIER_EARLY_TERM_EN.
package seq_multiplier_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Widest supported operand; magnitudes are computed one bit wider so that
  // the most negative operand still has a representable magnitude.
  localparam int MAX_W = 32;

  typedef logic [MAX_W:0] wide_t;

  function automatic int cnt_width(input int width);
    cnt_width = $clog2(width + 1);
  endfunction

  // Caller sign- or zero-extends the operand into wide_t according to
  // signed_mode; the low WIDTH bits of the result are the magnitude.
  function automatic wide_t abs_mag(input wide_t value, input logic signed_mode);
    if (signed_mode && value[MAX_W]) begin
      abs_mag = -value;
    end else begin
      abs_mag = value;
    end
  endfunction

endpackage

// File: rtl/seq_multiplier_mul_step.sv
// One shift-add iteration: conditional add of the multiplicand into the
// upper half of {carry, acc, mq}, then a one-bit right shift of the whole register.
module mul_step
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [2*WIDTH:0]  cur,
  input  logic [WIDTH-1:0]  mcand,
  output logic [2*WIDTH:0]  nxt
);

  logic [WIDTH:0]   upper;
  logic [WIDTH-1:0] mq;
  logic [WIDTH:0]   addend;
  logic [WIDTH:0]   sum;

  assign upper  = cur[2*WIDTH:WIDTH];
  assign mq     = cur[WIDTH-1:0];
  assign addend = mq[0] ? {1'b0, mcand} : '0;
  assign sum    = upper + addend;

  // The add never overflows WIDTH+1 bits because the running partial product
  // is always below 2^WIDTH * (2^WIDTH - 1) before alignment.
  assign nxt = {1'b0, sum, mq[WIDTH-1:1]};

endmodule

// File: rtl/seq_multiplier.sv
// Iterative WIDTH x WIDTH shift-add multiplier, unsigned or two's-complement per
// transaction, valid/ready on both sides. Macro: SEQ_MULTIPLIER_EARLY_TERM_EN.
module seq_multiplier
  import seq_multiplier_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   product
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam int REG_W = 2 * WIDTH + 1;

  localparam logic [1:0] S_IDLE = ST_IDLE;
  localparam logic [1:0] S_BUSY = ST_BUSY;
  localparam logic [1:0] S_FIX  = ST_FIX;
  localparam logic [1:0] S_DONE = ST_DONE;

  logic [1:0]         state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [REG_W-1:0]   reg_q;
  logic [WIDTH-1:0]   mcand_q;
  logic               neg_q;
  logic [2*WIDTH-1:0] product_q;

  logic [REG_W-1:0]   step_next;
  logic [WIDTH-1:0]   a_mag;
  logic [WIDTH-1:0]   b_mag;
  wide_t              a_ext;
  wide_t              b_ext;
  logic               last_step;
  logic [2*WIDTH-1:0] fix_val;

  assign a_ext = {{(MAX_W + 1 - WIDTH){signed_mode & a[WIDTH-1]}}, a};
  assign b_ext = {{(MAX_W + 1 - WIDTH){signed_mode & b[WIDTH-1]}}, b};
  assign a_mag = WIDTH'(abs_mag(a_ext, signed_mode));
  assign b_mag = WIDTH'(abs_mag(b_ext, signed_mode));

  mul_step #(.WIDTH(WIDTH)) u_step (
    .cur   (reg_q),
    .mcand (mcand_q),
    .nxt   (step_next)
  );

`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
  logic [WIDTH-1:0] live_bits;

  // The low cnt_q bits of mq are still original multiplier bits; once none
  // remain above the one consumed this cycle, the rest is pure shifting.
  assign live_bits = reg_q[WIDTH-1:0] & ~({WIDTH{1'b1}} << cnt_q);
  assign last_step = (cnt_q == CNT_W'(1)) || ((live_bits >> 1) == '0);
  assign fix_val   = reg_q[2*WIDTH-1:0] >> cnt_q;
`else
  assign last_step = (cnt_q == CNT_W'(1));
  assign fix_val   = reg_q[2*WIDTH-1:0];
`endif

  assign in_ready  = (state_q == S_IDLE);
  assign out_valid = (state_q == S_DONE);
  assign product   = product_q;

  // NOTE: all state updates use non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      reg_q     <= '0;
      mcand_q   <= '0;
      neg_q     <= 1'b0;
      product_q <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            mcand_q <= a_mag;
            reg_q   <= {1'b0, {WIDTH{1'b0}}, b_mag};
            neg_q   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            cnt_q   <= CNT_W'(WIDTH);
`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
            state_q <= (b_mag == '0) ? S_FIX : S_BUSY;
`else
            state_q <= S_BUSY;
`endif
          end
        end
        S_BUSY: begin
          reg_q <= step_next;
          cnt_q <= cnt_q - CNT_W'(1);
          if (last_step) begin
            state_q <= S_FIX;
          end
        end
        S_FIX: begin
          product_q <= neg_q ? -fix_val : fix_val;
          state_q   <= S_DONE;
        end
        S_DONE: begin
          if (out_ready) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
